uart_tx_scheduler: RTL and testbench

UART_TX_SCHEDULER -- requirements
Module: uart_tx_scheduler

---
 rtl/uart_tx_scheduler.sv | 213 +++++++++++++++++++++
 tb/tb_uart_tx_scheduler.sv | 391 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_scheduler.sv
// ============================================================================
// uart_tx_scheduler
// ----------------------------------------------------------------------------
// Shares one byte-oriented UART transmitter between four requesters.
//
// A requester becomes owner by winning a round-robin arbitration while the
// scheduler is idle. It keeps the transmitter until it delivers a byte marked
// "last". Each byte is handed to the transmitter with a one-cycle tx_start
// pulse. The scheduler then waits for the transmitter to acknowledge by
// raising tx_busy, and then waits for tx_busy to fall. After that it enforces
// an idle gap before the next byte. A transmitter that never acknowledges
// raises a sticky error and frees the grant so the system cannot lock up.
//
// Parameters
//   GAP_CYCLES   idle clk cycles held between consecutive bytes
//   ACK_TIMEOUT  clk cycles allowed between tx_start and tx_busy rising
//
// Ports
//   clk          clock, all logic on the rising edge
//   rst          asynchronous, active-high reset
//   req_valid    [3:0]  per-requester byte available
//   req_data     [31:0] byte of requester i on bits [8i+7:8i]
//   req_last     [3:0]  per-requester final-byte-of-burst flag
//   req_ready    [3:0]  one-hot pulse: byte of requester i accepted
//   tx_start     one-cycle start pulse to the transmitter
//   tx_byte      [7:0]  byte to transmit, held until the next acceptance
//   tx_busy      transmitter busy (START through STOP)
//   grant        [1:0]  index of current owner, valid with grant_valid
//   grant_valid  a requester owns the transmitter
//   err_timeout  sticky: transmitter failed to acknowledge tx_start
// ============================================================================
module uart_tx_scheduler #(
    parameter int GAP_CYCLES  = 2,
    parameter int ACK_TIMEOUT = 15
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [3:0]  req_valid,
    input  logic [31:0] req_data,
    input  logic [3:0]  req_last,
    output logic [3:0]  req_ready,
    output logic        tx_start,
    output logic [7:0]  tx_byte,
    input  logic        tx_busy,
    output logic [1:0]  grant,
    output logic        grant_valid,
    output logic        err_timeout
);

    // Counter widths never collapse to zero bits, even for tiny parameters.
    localparam int ACK_W = (ACK_TIMEOUT < 2) ? 1 : $clog2(ACK_TIMEOUT + 1);
    localparam int GAP_W = (GAP_CYCLES < 2) ? 1 : $clog2(GAP_CYCLES + 1);

    // The acknowledge counter starts at zero on the first WAIT_ACK cycle.
    // Reaching ACK_TIMEOUT-1 without tx_busy therefore means ACK_TIMEOUT
    // cycles have elapsed since tx_start rose.
    localparam logic [ACK_W-1:0] ACK_LAST = ACK_W'(ACK_TIMEOUT - 1);
    localparam logic [GAP_W-1:0] GAP_LOAD = GAP_W'(GAP_CYCLES);

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_ISSUE     = 3'd1,
        ST_WAIT_ACK  = 3'd2,
        ST_WAIT_DONE = 3'd3,
        ST_GAP       = 3'd4
    } state_t;

    // ------------------------------------------------------------------
    // Round-robin search. The search starts one past the previous winner
    // and goes upward with wraparound. The result is {found, index}.
    // ------------------------------------------------------------------
    function automatic logic [2:0] rr_pick(input logic [3:0] valid,
                                           input logic [1:0] last);
        logic [2:0] result;
        logic [1:0] cand;
        result = 3'b000;
        for (int k = 1; k <= 4; k++) begin
            cand = last + 2'(k);
            if (!result[2] && valid[cand]) begin
                result = {1'b1, cand};
            end
        end
        return result;
    endfunction

    state_t           state_r;
    logic [1:0]       last_winner_r;
    logic             last_byte_r;
    logic [ACK_W-1:0] ack_cnt_r;
    logic [GAP_W-1:0] gap_cnt_r;
    logic [3:0]       req_ready_r;
    logic             tx_start_r;
    logic [7:0]       tx_byte_r;
    logic [1:0]       grant_r;
    logic             grant_valid_r;
    logic             err_timeout_r;

    logic [2:0]       pick_s;
    logic             owner_valid_s;
    logic [7:0]       owner_byte_s;
    logic             owner_last_s;

    // Arbitration result and the current owner's request lane.
    always_comb begin
        pick_s        = rr_pick(req_valid, last_winner_r);
        owner_valid_s = req_valid[grant_r];
        owner_byte_s  = req_data[{grant_r, 3'b000} +: 8];
        owner_last_s  = req_last[grant_r];
    end

    // Scheduler FSM. All outputs are registered here.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r       <= ST_IDLE;
            last_winner_r <= 2'd3;
            last_byte_r   <= 1'b0;
            ack_cnt_r     <= '0;
            gap_cnt_r     <= '0;
            req_ready_r   <= 4'b0000;
            tx_start_r    <= 1'b0;
            tx_byte_r     <= 8'h00;
            grant_r       <= 2'd0;
            grant_valid_r <= 1'b0;
            err_timeout_r <= 1'b0;
        end else begin
            // Pulse outputs default low. Only acceptance raises them.
            tx_start_r  <= 1'b0;
            req_ready_r <= 4'b0000;

            case (state_r)
                ST_IDLE: begin
                    if (pick_s[2]) begin
                        grant_r       <= pick_s[1:0];
                        grant_valid_r <= 1'b1;
                        state_r       <= ST_ISSUE;
                    end else begin
                        grant_valid_r <= 1'b0;
                    end
                end

                // A stalled owner keeps the grant. Other requesters wait.
                // The tx_busy guard keeps a misbehaving transmitter from
                // ever seeing a start pulse while it is still sending.
                ST_ISSUE: begin
                    if (owner_valid_s && !tx_busy) begin
                        tx_start_r  <= 1'b1;
                        tx_byte_r   <= owner_byte_s;
                        req_ready_r <= 4'b0001 << grant_r;
                        last_byte_r <= owner_last_s;
                        ack_cnt_r   <= '0;
                        state_r     <= ST_WAIT_ACK;
                    end else begin
                        state_r     <= ST_ISSUE;
                    end
                end

                // The byte is already consumed, so it is not retried on
                // timeout. last_winner is left unchanged because the burst
                // never completed.
                ST_WAIT_ACK: begin
                    if (tx_busy) begin
                        state_r <= ST_WAIT_DONE;
                    end else if (ack_cnt_r == ACK_LAST) begin
                        err_timeout_r <= 1'b1;
                        grant_valid_r <= 1'b0;
                        ack_cnt_r     <= '0;
                        state_r       <= ST_IDLE;
                    end else begin
                        ack_cnt_r <= ack_cnt_r + ACK_W'(1);
                    end
                end

                ST_WAIT_DONE: begin
                    if (!tx_busy) begin
                        gap_cnt_r <= GAP_LOAD;
                        state_r   <= ST_GAP;
                    end else begin
                        state_r   <= ST_WAIT_DONE;
                    end
                end

                // The terminal count is checked before decrementing. With a
                // load of zero, GAP lasts exactly one cycle.
                ST_GAP: begin
                    if (gap_cnt_r == '0) begin
                        if (last_byte_r) begin
                            grant_valid_r <= 1'b0;
                            last_winner_r <= grant_r;
                            state_r       <= ST_IDLE;
                        end else begin
                            state_r       <= ST_ISSUE;
                        end
                    end else begin
                        gap_cnt_r <= gap_cnt_r - GAP_W'(1);
                    end
                end

                default: begin
                    grant_valid_r <= 1'b0;
                    state_r       <= ST_IDLE;
                end
            endcase
        end
    end

    assign req_ready   = req_ready_r;
    assign tx_start    = tx_start_r;
    assign tx_byte     = tx_byte_r;
    assign grant       = grant_r;
    assign grant_valid = grant_valid_r;
    assign err_timeout = err_timeout_r;

endmodule

// File: tb/tb_uart_tx_scheduler.sv
`timescale 1ns/1ps
// Self-checking bench for uart_tx_scheduler: a table of single-byte
// arbitrations, directed burst/stall/contention/timeout/reset sequences, and
// randomized traffic checked against a burst-level round-robin model.
module tb_uart_tx_scheduler;

    localparam int GAP_CYCLES  = 2;
    localparam int ACK_TIMEOUT = 15;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  req_valid;
    logic [31:0] req_data;
    logic [3:0]  req_last;
    logic [3:0]  req_ready;
    logic        tx_start;
    logic [7:0]  tx_byte;
    logic        tx_busy;
    logic [1:0]  grant;
    logic        grant_valid;
    logic        err_timeout;

    always #5 clk = ~clk;

    uart_tx_scheduler #(.GAP_CYCLES(GAP_CYCLES), .ACK_TIMEOUT(ACK_TIMEOUT)) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_data(req_data),
        .req_last(req_last), .req_ready(req_ready), .tx_start(tx_start),
        .tx_byte(tx_byte), .tx_busy(tx_busy), .grant(grant),
        .grant_valid(grant_valid), .err_timeout(err_timeout)
    );

    int errors = 0;
    int checks = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- UART transmitter model ----------------
    bit uart_en  = 1'b1;
    bit ack_rand = 1'b0;
    int busy_len = 0;

    initial begin
        int d;
        int dur;
        tx_busy = 1'b0;
        forever begin
            @(negedge clk);
            if (tx_start && uart_en) begin
                d   = ack_rand ? int'($urandom_range(0, 3)) : 0;
                dur = (busy_len > 0) ? busy_len : int'($urandom_range(3, 8));
                repeat (d) @(negedge clk);
                #1 tx_busy = 1'b1;
                repeat (dur) @(negedge clk);
                #1 tx_busy = 1'b0;
            end
        end
    end

    // ---------------- monitor / scoreboard ----------------
    logic [7:0] exp_q[$];
    logic [1:0] own_q[$];
    bit         sb_on = 1'b0;
    int         idle_cnt = 0;
    bit         seen_busy = 1'b0;
    bit         hold_on = 1'b0;
    logic [7:0] held;
    int         exp_lw = 3;

    always @(negedge clk) begin
        logic [7:0] e;
        logic [1:0] o;
        if (rst) begin
            hold_on   = 1'b0;
            seen_busy = 1'b0;
            idle_cnt  = 0;
        end else begin
            if (tx_start) begin
                check("start_while_busy", tx_busy, 1'b0);
                // Busy fall -> WAIT_DONE edge, GAP_CYCLES+1 GAP edges, ISSUE edge.
                if (seen_busy) check("gap_too_short", idle_cnt >= GAP_CYCLES + 2, 1'b1);
                held    = tx_byte;
                hold_on = 1'b1;
                if (sb_on) begin
                    if (exp_q.size() == 0) begin
                        check("unexpected_start", tx_byte, 8'h00 ^ ~tx_byte);
                    end else begin
                        e = exp_q.pop_front();
                        o = own_q.pop_front();
                        check("sb_byte", tx_byte, e);
                        check("sb_grant", grant, o);
                        check("sb_ready", req_ready, 4'b0001 << o);
                    end
                end
            end
            if (req_ready != 4'b0000) check("ready_onehot_with_start", {$onehot(req_ready), tx_start}, 2'b11);
            if (hold_on && tx_busy) check("tx_byte_hold", tx_byte, held);
            if (tx_busy) begin
                idle_cnt  = 0;
                seen_busy = 1'b1;
            end else if (idle_cnt < 100000) begin
                idle_cnt++;
            end
        end
    end

    // ---------------- traffic engine with reference model ----------------
    logic [7:0] rq_data[4][$];
    bit         rq_last[4][$];

    task automatic wait_release(input string tag);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (grant_valid && n < 300);
        check(tag, grant_valid, 1'b0);
    endtask

    // stall_mode: -1 none, 0 random, >0 fixed owner stall length after each mid-burst byte
    task automatic run_traffic(input int stall_mode, input string tag);
        int  head[4];
        int  ptr[4];
        int  stall[4];
        bit  mid[4];
        int  c;
        int  ct;
        bit  found;
        bit  l;
        int  cyc;
        bit  done;
        // Model: whole bursts are granted round-robin among non-empty requesters.
        for (int i = 0; i < 4; i++) head[i] = 0;
        forever begin
            found = 1'b0;
            c = 0;
            for (int k = 1; k <= 4; k++) begin
                ct = (exp_lw + k) % 4;
                if (!found && head[ct] < rq_data[ct].size()) begin
                    found = 1'b1;
                    c = ct;
                end
            end
            if (!found) break;
            do begin
                exp_q.push_back(rq_data[c][head[c]]);
                own_q.push_back(2'(c));
                l = rq_last[c][head[c]];
                head[c]++;
            end while (!l);
            exp_lw = c;
        end
        for (int i = 0; i < 4; i++) begin
            ptr[i] = 0; stall[i] = 0; mid[i] = 1'b0;
        end
        sb_on = 1'b1;
        cyc = 0;
        done = 1'b0;
        while (!done && cyc < 5000) begin
            #1;
            for (int i = 0; i < 4; i++) begin
                if (ptr[i] < rq_data[i].size() && stall[i] == 0) begin
                    req_valid[i]       = 1'b1;
                    req_data[8*i +: 8] = rq_data[i][ptr[i]];
                    req_last[i]        = rq_last[i][ptr[i]];
                end else begin
                    req_valid[i]       = 1'b0;
                    req_data[8*i +: 8] = 8'h00;
                    req_last[i]        = 1'b0;
                end
            end
            @(negedge clk);
            cyc++;
            for (int i = 0; i < 4; i++) begin
                if (req_ready[i]) begin
                    ptr[i]++;
                    mid[i] = !rq_last[i][ptr[i]-1];
                    if (mid[i] && stall_mode > 0) stall[i] = stall_mode;
                    else if (mid[i] && stall_mode == 0 && $urandom_range(0, 3) == 0) stall[i] = int'($urandom_range(1, 6));
                    else stall[i] = 0;
                end else if (stall[i] > 0) begin
                    check({tag, "_stall_hold"}, {grant_valid, grant}, {1'b1, 2'(i)});
                    stall[i]--;
                end
            end
            done = !grant_valid && !tx_busy;
            for (int i = 0; i < 4; i++) if (ptr[i] < rq_data[i].size()) done = 1'b0;
        end
        check({tag, "_done"}, done, 1'b1);
        check({tag, "_sb_empty"}, exp_q.size(), 0);
        sb_on = 1'b0;
        exp_q.delete();
        own_q.delete();
        for (int i = 0; i < 4; i++) begin
            rq_data[i].delete();
            rq_last[i].delete();
        end
        req_valid = 4'b0000;
    endtask

    // ---------------- table vectors ----------------
    typedef struct {
        logic [3:0]  valid;
        logic [31:0] data;
        logic [1:0]  exp_grant;
        logic [7:0]  exp_byte;
    } vec_t;
    vec_t vecs[12];

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat;
        int n;
        int starts;
        bit got;
        int len;
        int nb;

        vecs[0]  = '{4'b0001, 32'h000000A5, 2'd0, 8'hA5};
        vecs[1]  = '{4'b1111, 32'h44332211, 2'd1, 8'h22};
        vecs[2]  = '{4'b1001, 32'h8C7B6A59, 2'd3, 8'h8C};
        vecs[3]  = '{4'b0110, 32'h00F0E000, 2'd1, 8'hE0};
        vecs[4]  = '{4'b0011, 32'h12345678, 2'd0, 8'h78};
        vecs[5]  = '{4'b1000, 32'hDEADBEEF, 2'd3, 8'hDE};
        vecs[6]  = '{4'b0100, 32'h00FF0000, 2'd2, 8'hFF};
        vecs[7]  = '{4'b1111, 32'hCAFEF00D, 2'd3, 8'hCA};
        vecs[8]  = '{4'b0011, 32'h00005A3C, 2'd0, 8'h3C};
        vecs[9]  = '{4'b1101, 32'h99887766, 2'd2, 8'h88};
        vecs[10] = '{4'b1010, 32'h01020304, 2'd3, 8'h01};
        vecs[11] = '{4'b0010, 32'h00008100, 2'd1, 8'h81};

        rst = 1'b1;
        req_valid = 4'b0000;
        req_data  = 32'h0;
        req_last  = 4'b0000;
        #2;
        check("rst_tx_start", tx_start, 1'b0);
        check("rst_tx_byte", tx_byte, 8'h00);
        check("rst_req_ready", req_ready, 4'b0000);
        check("rst_grant", {grant_valid, grant}, 3'b000);
        check("rst_err", err_timeout, 1'b0);
        repeat (3) @(negedge clk);
        #1 rst = 1'b0;
        exp_lw = 3;

        // Table: single-byte arbitrations from IDLE.
        for (int v = 0; v < 12; v++) begin
            @(negedge clk);
            #1;
            req_valid = vecs[v].valid;
            req_data  = vecs[v].data;
            req_last  = 4'b1111;
            lat = 0;
            got = 1'b0;
            while (!got && lat < 20) begin
                @(negedge clk);
                lat++;
                if (tx_start) got = 1'b1;
            end
            check("tbl_latency", lat, 2);
            check("tbl_grant", {grant_valid, grant}, {1'b1, vecs[v].exp_grant});
            check("tbl_ready", req_ready, 4'b0001 << vecs[v].exp_grant);
            check("tbl_byte", tx_byte, vecs[v].exp_byte);
            #1 req_valid = 4'b0000;
            wait_release("tbl_release");
            check("tbl_byte_held", tx_byte, vecs[v].exp_byte);
            exp_lw = vecs[v].exp_grant;
        end

        // Burst lock: requester 2 sends three bytes while requester 0 waits.
        rq_data[2].push_back(8'h21); rq_last[2].push_back(1'b0);
        rq_data[2].push_back(8'h22); rq_last[2].push_back(1'b0);
        rq_data[2].push_back(8'h23); rq_last[2].push_back(1'b1);
        rq_data[0].push_back(8'h01); rq_last[0].push_back(1'b1);
        run_traffic(-1, "burst");

        // Owner stalls 10 cycles mid-burst while requester 3 waits.
        rq_data[1].push_back(8'hA1); rq_last[1].push_back(1'b0);
        rq_data[1].push_back(8'hA2); rq_last[1].push_back(1'b1);
        rq_data[3].push_back(8'hB3); rq_last[3].push_back(1'b1);
        run_traffic(10, "stall");

        // Contention: all requesters valid, single-byte bursts.
        for (int i = 0; i < 4; i++) begin
            rq_data[i].push_back(8'hC0 + 8'(i)); rq_last[i].push_back(1'b1);
        end
        rq_data[0].push_back(8'hC4); rq_last[0].push_back(1'b1);
        run_traffic(-1, "contend");

        // Timeout: transmitter never acknowledges.
        uart_en = 1'b0;
        @(negedge clk);
        #1;
        req_valid = 4'b0001;
        req_data  = 32'h0000003C;
        req_last  = 4'b0001;
        n = 0;
        while (!tx_start && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("to_start", tx_start, 1'b1);
        #1 req_valid = 4'b0000;
        n = 0;
        while (!err_timeout && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("to_latency", n, ACK_TIMEOUT);
        check("to_grant_dropped", grant_valid, 1'b0);
        repeat (20) @(negedge clk);
        check("to_sticky", err_timeout, 1'b1);
        #1 rst = 1'b1;
        #1 check("to_rst_clear", err_timeout, 1'b0);
        repeat (2) @(negedge clk);
        #1 rst = 1'b0;
        uart_en = 1'b1;
        exp_lw = 3;

        // Reset while the transmitter is busy (WAIT_DONE).
        busy_len = 10;
        @(negedge clk);
        #1;
        req_valid = 4'b1111;
        req_data  = 32'h44332211;
        req_last  = 4'b1111;
        n = 0;
        while (!tx_busy && n < 20) begin
            @(negedge clk);
            n++;
        end
        @(negedge clk);
        check("rw_busy", tx_busy, 1'b1);
        #1 rst = 1'b1;
        #1;
        check("rw_tx_start", tx_start, 1'b0);
        check("rw_tx_byte", tx_byte, 8'h00);
        check("rw_req_ready", req_ready, 4'b0000);
        check("rw_grant", {grant_valid, grant}, 3'b000);
        starts = 0;
        n = 0;
        while ((tx_busy || n < 4) && n < 40) begin
            @(negedge clk);
            n++;
            if (tx_start) starts++;
        end
        check("rw_no_start_in_rst", starts, 0);
        #1 rst = 1'b0;
        busy_len = 0;
        @(negedge clk);
        check("rw_first_grant", {grant_valid, grant}, 3'b100);
        @(negedge clk);
        check("rw_first_start", tx_start, 1'b1);
        check("rw_first_byte", tx_byte, 8'h11);
        check("rw_first_ready", req_ready, 4'b0001);
        #1 req_valid = 4'b0000;
        wait_release("rw_release");
        exp_lw = 0;

        // Randomized traffic with random ack delays and owner stalls.
        ack_rand = 1'b1;
        for (int r = 0; r < 3; r++) begin
            for (int i = 0; i < 4; i++) begin
                nb = int'($urandom_range(0, 3));
                for (int b = 0; b < nb; b++) begin
                    len = int'($urandom_range(1, 4));
                    for (int j = 0; j < len; j++) begin
                        rq_data[i].push_back(8'($urandom_range(0, 255)));
                        rq_last[i].push_back(j == len - 1);
                    end
                end
            end
            @(negedge clk);
            run_traffic(0, "rand");
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
